parity_frame_tx: RTL and testbench
==================================

# parity_frame_tx

Serial frame transmitter that sits directly downstream of the 8-bit parity generator. It accepts a byte plus its already-computed parity bit through a valid/ready handshake. It then shifts out an 11-bit asynchronous-style frame on a single line: start bit, 8 data bits LSB first, parity bit, stop bit. Each bit lasts a programmable number of clock cycles.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..1024.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  8  byte to send (D0 = bit 0, sent first).
- parity_in  in  1  parity bit from the upstream generator, sent unmodified.
- valid_in  in  1  data_in/parity_in are valid this cycle.
- ready_out  out  1  block can accept a byte this cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in flight.
- frame_done  out  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - ready_out=1, tx=1, busy=0.
  - If valid_in && ready_out at a rising edge: latch data_in into the shift register, latch parity_in, and go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit 0 for CLKS_PER_BIT cycles, then shift right and increment the bit index.
  - After index 7 completes, go to PARITY.
- PARITY:
  - tx = latched parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the last of those cycles, then return to IDLE.
- In every non-IDLE state: ready_out=0, busy=1.
- valid_in is ignored while ready_out=0. Inputs are not sampled after acceptance, so upstream may change them freely.
- The parity bit is not recomputed or checked; parity_in is transmitted verbatim.
- Bit-cycle counter is $clog2(CLKS_PER_BIT)+1 bits wide. It counts 0..CLKS_PER_BIT-1 and resets to 0 on every state/bit change.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; the counter is trivially always at terminal count.

## Timing
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Reset values: tx=1, ready_out=1, busy=0, frame_done=0; state=IDLE; counters=0.
- Accept at edge k: tx=0 and busy=1 from cycle k+1.
- Frame length: 11*CLKS_PER_BIT cycles from the first start cycle to the last stop cycle.
- Back-to-back frames:
  - ready_out returns high in the cycle after the last stop cycle.
  - The minimum gap is therefore one extra idle-high cycle: frame period = 11*CLKS_PER_BIT + 1 cycles.
- Reset mid-frame: at the rst edge the frame is aborted. tx=1, ready_out=1, busy=0 from the next cycle; no frame_done is produced.
- rst has priority over the handshake. A byte presented while rst=1 is not accepted.

## Structure
- Shared package parity_frame_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - FRAME_BITS=11;
  - DATA_BITS=8.
- One natural sub-module: bit_timer.
  - Parameterised on CLKS_PER_BIT.
  - Inputs: clk, rst, restart.
  - Output: tick (terminal-count strobe).
  - Instantiated once; the FSM advances on tick.

## Test plan
- Reset:
  - Hold rst for 3 cycles, then release.
  - tx=1, ready_out=1, busy=0, frame_done=0; all stable with valid_in=0.
- Single frame, CLKS_PER_BIT=4:
  - Send data_in=0xB2, parity_in=0.
  - tx bit sequence is 0,0,1,0,0,1,1,0,1,0,1, each bit held 4 cycles (44 cycles total).
  - frame_done pulses exactly once, at cycle 44 after acceptance.
- Odd parity bit:
  - Send data_in=0x01, parity_in=1.
  - Parity slot (bit 10) is high; data slots are 1,0,0,0,0,0,0,0.
- Back-to-back:
  - Hold valid_in=1 continuously with 0x55, then 0xAA.
  - Second acceptance occurs exactly 45 cycles after the first, with exactly one idle-high cycle between frames.
  - valid_in asserted during a frame is not accepted.
- Mid-frame reset:
  - Assert rst during DATA bit 3 of 0xFF.
  - Next cycle: tx=1, ready_out=1, busy=0; no frame_done.
  - A new byte 0x0F is then sent correctly.
- CLKS_PER_BIT=1:
  - Send 0xC3, parity_in=0.
  - 11-cycle frame 0,1,1,0,0,0,0,1,1,0,1; ready_out high again on cycle 12.

Source files
------------

// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity frame transmitter.
// The frame is start + DATA_BITS data bits (LSB first) + parity + stop.
package parity_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  localparam int IDX_W      = $clog2(DATA_BITS);

  // Bit-cycle counter width; the extra bit keeps CLKS_PER_BIT=1 at one bit wide.
  function automatic int bit_cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit) + 1;
  endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes tick on the last count.
// restart holds the count at zero so the first bit of a frame gets a full period.
module bit_timer
  import parity_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = bit_cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign tick = (cnt_reg == TERMINAL);

  always_comb begin
    cnt_next = cnt_reg + ONE;
    if (restart || tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: accepts a byte plus upstream parity, then sends
// start, 8 data bits LSB first, parity and stop, each CLKS_PER_BIT cycles long.
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       parity_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t                 state_reg, state_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   parity_reg, parity_next;
  logic [IDX_W-1:0]       bit_idx_reg, bit_idx_next;
  logic                   tick;
  logic                   timer_restart;

  // The timer idles at zero, so its wrap lines up with every state/bit change.
  assign timer_restart = (state_reg == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(timer_restart),
    .tick   (tick)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    bit_idx_next = bit_idx_reg;
    ready_out    = 1'b0;
    busy         = 1'b1;
    tx           = 1'b1;
    frame_done   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        ready_out = 1'b1;
        busy      = 1'b0;
        if (valid_in) begin
          shift_next   = data_in;
          parity_next  = parity_in;
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (tick) begin
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        tx = shift_reg[0];
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == LAST_IDX) begin
            state_next = PARITY;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_ONE;
          end
        end
      end
      PARITY: begin
        tx = parity_reg;
        if (tick) begin
          state_next = STOP;
        end
      end
      STOP: begin
        tx         = 1'b1;
        frame_done = tick;
        if (tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      bit_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      bit_idx_reg <= bit_idx_next;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
// Expected line waveforms come from the frame layout, not from the design internals.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [2];
  logic       par [2];
  logic       vld [2];
  logic       rdy [2];
  logic       txs [2];
  logic       bsy [2];
  logic       fd  [2];
  int         cpb [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(din[0]), .parity_in(par[0]), .valid_in(vld[0]),
    .ready_out(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .frame_done(fd[0])
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .parity_in(par[1]), .valid_in(vld[1]),
    .ready_out(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .frame_done(fd[1])
  );

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       p;
    logic [10:0] seq;  // seq[10] is the first bit on the line
  } vec_t;

  vec_t tbl [3];

  // Reference: line sequence built from the frame layout.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic p);
    logic [10:0] f;
    f[10] = 1'b0;
    for (int i = 0; i < 8; i++) f[9-i] = d[i];
    f[1] = p;
    f[0] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (time %0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input int s, input string tag);
    chk($sformatf("%s ready[%0d]", tag, s), rdy[s], 1'b1);
    chk($sformatf("%s tx[%0d]", tag, s), txs[s], 1'b1);
    chk($sformatf("%s busy[%0d]", tag, s), bsy[s], 1'b0);
    chk($sformatf("%s done[%0d]", tag, s), fd[s], 1'b0);
  endtask

  // Waits (bounded) for ready, presents the byte, returns just after the accept edge.
  task automatic accept(input int s, input logic [7:0] d, input logic p, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    din[s] = d; par[s] = p; vld[s] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rdy[s] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout[%0d]: ready never rose, expected within 200 cycles", s);
      vld[s] = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // Called right after an accept edge: checks the whole frame plus the idle cycle after it.
  task automatic check_frame(input int s, input logic [10:0] seq, input bit hold,
                             input logic [7:0] next_d, input logic next_p);
    int n;
    n = 11 * cpb[s];
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      if (t == 1) begin
        if (hold) begin
          din[s] = next_d; par[s] = next_p;
        end else begin
          vld[s] = 1'b0; din[s] = 8'($urandom); par[s] = 1'($urandom);
        end
      end
      chk($sformatf("tx[%0d] t=%0d", s, t), txs[s], seq[10 - (t-1)/cpb[s]]);
      chk($sformatf("busy[%0d] t=%0d", s, t), bsy[s], 1'b1);
      chk($sformatf("ready[%0d] t=%0d", s, t), rdy[s], 1'b0);
      chk($sformatf("done[%0d] t=%0d", s, t), fd[s], (t == n) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    chk_idle(s, "post_frame");
    $display("frame dut%0d seq=%b checked (%0d cycles)", s, seq, n);
  endtask

  initial begin
    bit ok;
    bit any_done;
    logic [7:0] d;
    logic p;
    int s;

    cpb[0] = 4; cpb[1] = 1;
    for (int i = 0; i < 2; i++) begin
      din[i] = 8'h00; par[i] = 1'b0; vld[i] = 1'b0;
    end
    tbl[0] = '{sel: 0, d: 8'hB2, p: 1'b0, seq: 11'b00100110101};
    tbl[1] = '{sel: 0, d: 8'h01, p: 1'b1, seq: 11'b01000000011};
    tbl[2] = '{sel: 1, d: 8'hC3, p: 1'b0, seq: 11'b01100001101};

    // Reset held three cycles, then idle stability
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk_idle(i, "reset");
    end
    $display("reset checked");

    // Directed table
    for (int i = 0; i < 3; i++) begin
      accept(tbl[i].sel, tbl[i].d, tbl[i].p, ok);
      if (ok) check_frame(tbl[i].sel, tbl[i].seq, 1'b0, 8'h00, 1'b0);
    end

    // Back-to-back with valid held high: second accept 45 cycles after the first
    accept(0, 8'h55, 1'b0, ok);
    if (ok) begin
      check_frame(0, model_frame(8'h55, 1'b0), 1'b1, 8'hAA, 1'b0);
      check_frame(0, model_frame(8'hAA, 1'b0), 1'b0, 8'h00, 1'b0);
    end

    // Mid-frame reset during data bit 3 of 0xFF
    accept(0, 8'hFF, 1'b1, ok);
    if (ok) begin
      for (int t = 1; t <= 17; t++) begin
        @(negedge clk);
        if (t == 1) vld[0] = 1'b0;
      end
      chk("bit3 tx before reset", txs[0], 1'b1);
      chk("bit3 busy before reset", bsy[0], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_idle(0, "after_midframe_rst");
      any_done = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (fd[0] === 1'b1 || bsy[0] !== 1'b0) any_done = 1'b1;
      end
      chk("no frame after abort", any_done, 1'b0);
      accept(0, 8'h0F, 1'b0, ok);
      if (ok) check_frame(0, model_frame(8'h0F, 1'b0), 1'b0, 8'h00, 1'b0);
    end

    // rst has priority over a presented byte
    @(negedge clk);
    rst = 1'b1; vld[0] = 1'b1; din[0] = 8'h3C; vld[1] = 1'b1; din[1] = 8'h3C;
    @(negedge clk);
    rst = 1'b0; vld[0] = 1'b0; vld[1] = 1'b0;
    for (int i = 0; i < 2; i++) chk_idle(i, "rst_priority");
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk_idle(i, "rst_priority_next");

    // Randomized frames against the reference
    for (int k = 0; k < 24; k++) begin
      s = int'($urandom_range(0, 1));
      d = 8'($urandom);
      p = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(s, d, p, ok);
      if (ok) check_frame(s, model_frame(d, p), 1'b0, 8'h00, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
